// File: rtl/cc_read_completer_if.sv
// CQ descriptor, register-read and CC stream bundle
// for the BAR read completer.
interface cc_read_completer_if #(
  parameter int DATA_WIDTH = 256,
  parameter int BAR0_SIZE  = 16
);
  logic                    cq_valid;
  logic                    cq_is_read;
  logic [2:0]              cq_bar_id;
  logic [BAR0_SIZE-1:0]    cq_reg_addr;
  logic [10:0]             cq_dword_count;
  logic [15:0]             cq_requester_id;
  logic [7:0]              cq_tag;
  logic [2:0]              cq_tc;
  logic [6:0]              cq_lower_addr;
  logic                    reg_rd_en;
  logic [BAR0_SIZE-1:0]    reg_rd_addr;
  logic [63:0]             reg_rd_data;
  logic [DATA_WIDTH-1:0]   s_axis_cc_tdata;
  logic [DATA_WIDTH/32-1:0] s_axis_cc_tkeep;
  logic                    s_axis_cc_tlast;
  logic [32:0]             s_axis_cc_tuser;
  logic                    s_axis_cc_tvalid;
  logic                    s_axis_cc_tready;

  modport master (
    output cq_valid, cq_is_read, cq_bar_id,
    output cq_reg_addr, cq_dword_count,
    output cq_requester_id, cq_tag, cq_tc,
    output cq_lower_addr,
    input  reg_rd_en, reg_rd_addr,
    output reg_rd_data,
    input  s_axis_cc_tdata, s_axis_cc_tkeep,
    input  s_axis_cc_tlast, s_axis_cc_tuser,
    input  s_axis_cc_tvalid,
    output s_axis_cc_tready
  );

  modport slave (
    input  cq_valid, cq_is_read, cq_bar_id,
    input  cq_reg_addr, cq_dword_count,
    input  cq_requester_id, cq_tag, cq_tc,
    input  cq_lower_addr,
    output reg_rd_en, reg_rd_addr,
    input  reg_rd_data,
    output s_axis_cc_tdata, s_axis_cc_tkeep,
    output s_axis_cc_tlast, s_axis_cc_tuser,
    output s_axis_cc_tvalid,
    input  s_axis_cc_tready
  );
endinterface

// File: rtl/cc_read_completer.sv
// BAR memory-read completer: queues reads, fetches
// register data, emits single-beat CC completions.
module cc_read_completer #(
  parameter int DATA_WIDTH = 256,
  parameter int BAR0_SIZE  = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int BAR_ID     = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  cc_read_completer_if.slave bus,
  output logic          ovf_pulse,
  output logic [15:0]   ovf_count,
  output logic          busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int KW = DATA_WIDTH / 32;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] SEND = 2'd3;

  typedef struct packed {
    logic [BAR0_SIZE-1:0] addr;
    logic [10:0]          dw;
    logic [15:0]          rid;
    logic [7:0]           tag;
    logic [2:0]           tc;
    logic [6:0]           la;
  } req_t;

  req_t                  mem [FIFO_DEPTH];
  req_t                  in_req;
  req_t                  head;
  req_t                  cur;
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic                  empty;
  logic                  full;
  logic                  req;
  logic                  push;
  logic                  pop;
  logic                  drop;
  logic [1:0]            state;
  logic                  one_dw;
  logic                  two_dw;
  logic [DATA_WIDTH-1:0] nxt_data;
  logic [KW-1:0]         nxt_keep;

  assign in_req = '{
    addr: bus.cq_reg_addr,
    dw:   bus.cq_dword_count,
    rid:  bus.cq_requester_id,
    tag:  bus.cq_tag,
    tc:   bus.cq_tc,
    la:   bus.cq_lower_addr
  };

  assign head  = mem[rd_ptr[AW-1:0]];
  assign empty = wr_ptr == rd_ptr;
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign req   = bus.cq_valid & bus.cq_is_read &
                 (bus.cq_bar_id == 3'(BAR_ID));
  assign pop   = (state == IDLE) & ~empty;
  assign push  = req & (~full | pop);
  assign drop  = req & full & ~pop;
  assign busy  = ~empty | (state != IDLE);

  assign bus.s_axis_cc_tlast = bus.s_axis_cc_tvalid;
  assign bus.s_axis_cc_tuser = '0;

  // Queue storage; the slot freed by a same-cycle pop
  // is read before it is overwritten.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_req;
  end

  // Queue pointers and overflow accounting
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ovf_pulse <= 1'b0;
      ovf_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      ovf_pulse <= drop;
      if (drop && ovf_count != 16'hFFFF)
        ovf_count <= ovf_count + 16'd1;
    end
  end

  assign one_dw = cur.dw == 11'd1;
  assign two_dw = (cur.dw == 11'd2) && !cur.addr[2];

  // Completion beat built from the working request
  always_comb begin
    nxt_data = '0;
    nxt_keep = '0;
    nxt_data[6:0]   = cur.la;
    nxt_data[63:48] = cur.rid;
    nxt_data[71:64] = cur.tag;
    nxt_data[91:89] = cur.tc;
    unique case (1'b1)
      one_dw: begin
        nxt_data[28:16]  = 13'd4;
        nxt_data[42:32]  = 11'd1;
        nxt_data[127:96] = cur.addr[2] ?
                           bus.reg_rd_data[63:32] :
                           bus.reg_rd_data[31:0];
        nxt_keep = KW'(8'h0F);
      end
      two_dw: begin
        nxt_data[28:16]   = 13'd8;
        nxt_data[42:32]   = 11'd2;
        nxt_data[127:96]  = bus.reg_rd_data[31:0];
        nxt_data[159:128] = bus.reg_rd_data[63:32];
        nxt_keep = KW'(8'h1F);
      end
      default: begin
        nxt_data[45:43] = 3'b001;
        nxt_keep = KW'(8'h07);
      end
    endcase
  end

  // Read/complete sequencer with registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                <= IDLE;
      cur                  <= '0;
      bus.reg_rd_en        <= 1'b0;
      bus.reg_rd_addr      <= '0;
      bus.s_axis_cc_tvalid <= 1'b0;
      bus.s_axis_cc_tdata  <= '0;
      bus.s_axis_cc_tkeep  <= '0;
    end else begin
      bus.reg_rd_en <= 1'b0;
      unique case (state)
        IDLE: if (pop) begin
          cur             <= head;
          bus.reg_rd_en   <= 1'b1;
          bus.reg_rd_addr <=
            {head.addr[BAR0_SIZE-1:3], 3'b000};
          state           <= RD;
        end
        RD: state <= WAIT;
        WAIT: begin
          bus.s_axis_cc_tdata  <= nxt_data;
          bus.s_axis_cc_tkeep  <= nxt_keep;
          bus.s_axis_cc_tvalid <= 1'b1;
          state                <= SEND;
        end
        SEND: if (bus.s_axis_cc_tready) begin
          bus.s_axis_cc_tvalid <= 1'b0;
          state                <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cc_read_completer.sv
// Scoreboard bench for cc_read_completer.
// Directed reads, stalls, overflow and reset.
module tb_cc_read_completer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ovf_pulse;
  logic [15:0] ovf_count;
  logic        busy;

  int tests = 0;
  int fails = 0;
  int hs = 0;
  int ovf_seen = 0;

  typedef struct {
    logic [255:0] d;
    logic [7:0]   k;
  } beat_t;
  beat_t sb[$];

  cc_read_completer_if #(
    .DATA_WIDTH(256), .BAR0_SIZE(16)) bus();

  cc_read_completer #(
    .DATA_WIDTH(256), .BAR0_SIZE(16),
    .FIFO_DEPTH(4), .BAR_ID(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .ovf_pulse(ovf_pulse), .ovf_count(ovf_count),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] regval(
    input logic [15:0] a);
    if (a == 16'h0010) return 64'hDEADBEEF_CAFEF00D;
    return {16'h1000, a, 16'h2000, a};
  endfunction

  // Register file model: data one cycle after strobe
  always @(posedge clk) begin
    if (bus.reg_rd_en)
      bus.reg_rd_data <= regval(bus.reg_rd_addr);
    else
      bus.reg_rd_data <= 64'hBAD0_BAD0_BAD0_BAD0;
  end

  task automatic chk(input string n,
                     input logic [255:0] act,
                     input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%0h exp=%0h", n, act, exp);
    end
  endtask

  function automatic beat_t mk(
    input logic [6:0] la, input logic [12:0] bc,
    input logic [10:0] dwo, input logic [2:0] st,
    input logic [15:0] rid, input logic [7:0] tag,
    input logic [2:0] tc, input logic [31:0] p0,
    input logic [31:0] p1, input logic [7:0] k);
    beat_t b;
    b.d = '0;
    b.d[6:0] = la;
    b.d[28:16] = bc;
    b.d[42:32] = dwo;
    b.d[45:43] = st;
    b.d[63:48] = rid;
    b.d[71:64] = tag;
    b.d[91:89] = tc;
    b.d[127:96] = p0;
    b.d[159:128] = p1;
    b.k = k;
    return b;
  endfunction

  // Monitor: every handshake pops one expected beat
  always @(negedge clk) begin
    if (rst_n && bus.s_axis_cc_tvalid &&
        bus.s_axis_cc_tready) begin
      beat_t e;
      hs++;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_beat act=%0h exp=none",
                 bus.s_axis_cc_tdata);
      end else begin
        e = sb.pop_front();
        chk("beat_tdata", bus.s_axis_cc_tdata, e.d);
        chk("beat_tkeep", 256'(bus.s_axis_cc_tkeep),
            256'(e.k));
        chk("beat_tlast", 256'(bus.s_axis_cc_tlast),
            256'd1);
      end
    end
    if (ovf_pulse) ovf_seen++;
  end

  task automatic drive(
    input logic rd, input logic [2:0] bar,
    input logic [15:0] addr, input logic [10:0] dw,
    input logic [15:0] rid, input logic [7:0] tag,
    input logic [2:0] tc, input logic [6:0] la);
    bus.cq_valid = 1'b1;
    bus.cq_is_read = rd;
    bus.cq_bar_id = bar;
    bus.cq_reg_addr = addr;
    bus.cq_dword_count = dw;
    bus.cq_requester_id = rid;
    bus.cq_tag = tag;
    bus.cq_tc = tc;
    bus.cq_lower_addr = la;
    @(posedge clk);
    #1;
    bus.cq_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy || bus.s_axis_cc_tvalid) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) chk("idle_timeout", 256'd1, 256'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tvalid();
    int n = 0;
    @(negedge clk);
    while (!bus.s_axis_cc_tvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("tvalid_timeout", 256'd1, 256'd0);
  endtask

  initial begin
    beat_t e;
    int h0;
    rst_n = 1'b0;
    bus.cq_valid = 1'b0;
    bus.cq_is_read = 1'b0;
    bus.cq_bar_id = '0;
    bus.cq_reg_addr = '0;
    bus.cq_dword_count = '0;
    bus.cq_requester_id = '0;
    bus.cq_tag = '0;
    bus.cq_tc = '0;
    bus.cq_lower_addr = '0;
    bus.s_axis_cc_tready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", 256'(bus.s_axis_cc_tvalid), 0);
    chk("rst_tlast", 256'(bus.s_axis_cc_tlast), 0);
    chk("rst_rd_en", 256'(bus.reg_rd_en), 0);
    chk("rst_busy", 256'(busy), 0);
    chk("rst_ovf", 256'(ovf_pulse), 0);
    chk("rst_ovf_cnt", 256'(ovf_count), 0);
    chk("rst_tdata", bus.s_axis_cc_tdata, 0);
    chk("rst_tkeep", 256'(bus.s_axis_cc_tkeep), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1-DW read with cycle-exact latency
    sb.push_back(mk(7'h14, 13'd4, 11'd1, 3'd0,
      16'h0100, 8'h2A, 3'd0, 32'hDEADBEEF, 0, 8'h0F));
    drive(1, 0, 16'h0014, 11'd1, 16'h0100, 8'h2A, 0,
          7'h14);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk($sformatf("lat_rd_en_c%0d", c),
          256'(bus.reg_rd_en), 256'(c == 2));
      chk($sformatf("lat_tvalid_c%0d", c),
          256'(bus.s_axis_cc_tvalid), 256'(c == 4));
      if (c == 2)
        chk("rd_addr", 256'(bus.reg_rd_addr),
            256'h0010);
    end
    wait_idle();

    // Directed table: 2-DW, 1-DW low, UR cases
    sb.push_back(mk(7'h20, 13'd8, 11'd2, 3'd0,
      16'h0200, 8'h11, 3'd3, 32'h20000020,
      32'h10000020, 8'h1F));
    drive(1, 0, 16'h0020, 11'd2, 16'h0200, 8'h11, 3,
          7'h20);
    wait_idle();
    sb.push_back(mk(7'h18, 13'd4, 11'd1, 3'd0,
      16'h0200, 8'h12, 3'd0, 32'h20000018, 0, 8'h0F));
    drive(1, 0, 16'h0018, 11'd1, 16'h0200, 8'h12, 0,
          7'h18);
    wait_idle();
    sb.push_back(mk(7'h30, 13'd0, 11'd0, 3'd1,
      16'h0200, 8'h13, 3'd0, 0, 0, 8'h07));
    drive(1, 0, 16'h0030, 11'd3, 16'h0200, 8'h13, 0,
          7'h30);
    wait_idle();
    sb.push_back(mk(7'h40, 13'd0, 11'd0, 3'd1,
      16'h0200, 8'h14, 3'd0, 0, 0, 8'h07));
    drive(1, 0, 16'h0040, 11'd0, 16'h0200, 8'h14, 0,
          7'h40);
    wait_idle();
    sb.push_back(mk(7'h44, 13'd0, 11'd0, 3'd1,
      16'h0200, 8'h15, 3'd0, 0, 0, 8'h07));
    drive(1, 0, 16'h0044, 11'd2, 16'h0200, 8'h15, 0,
          7'h44);
    wait_idle();

    // Write to BAR0 and read to BAR1: ignored
    h0 = hs;
    drive(0, 0, 16'h0010, 11'd1, 16'h0200, 8'h16, 0,
          7'h10);
    drive(1, 1, 16'h0010, 11'd1, 16'h0200, 8'h17, 0,
          7'h10);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk($sformatf("ignored_busy_c%0d", c),
          256'(busy), 0);
    end
    chk("ignored_no_beat", 256'(hs), 256'(h0));
    @(posedge clk);
    #1;

    // Stall 10 cycles during SEND
    bus.s_axis_cc_tready = 1'b0;
    e = mk(7'h10, 13'd8, 11'd2, 3'd0, 16'h0300, 8'h21,
      3'd0, 32'hCAFEF00D, 32'hDEADBEEF, 8'h1F);
    sb.push_back(e);
    drive(1, 0, 16'h0010, 11'd2, 16'h0300, 8'h21, 0,
          7'h10);
    wait_tvalid();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("stall_tvalid", 256'(bus.s_axis_cc_tvalid), 1);
      chk("stall_tdata", bus.s_axis_cc_tdata, e.d);
      chk("stall_tkeep", 256'(bus.s_axis_cc_tkeep),
          256'(e.k));
    end
    h0 = hs;
    @(posedge clk);
    #1;
    bus.s_axis_cc_tready = 1'b1;
    repeat (3) @(negedge clk);
    chk("stall_one_hs", 256'(hs), 256'(h0 + 1));
    chk("stall_released", 256'(bus.s_axis_cc_tvalid), 0);
    wait_idle();

    // Overflow: engine stalled, 6 more reads
    bus.s_axis_cc_tready = 1'b0;
    sb.push_back(mk(7'h50, 13'd4, 11'd1, 3'd0,
      16'h0400, 8'h3F, 3'd0, 32'h20000050, 0, 8'h0F));
    drive(1, 0, 16'h0050, 11'd1, 16'h0400, 8'h3F, 0,
          7'h50);
    wait_tvalid();
    @(posedge clk);
    #1;
    ovf_seen = 0;
    h0 = hs;
    for (int i = 0; i < 6; i++) begin
      if (i < 4)
        sb.push_back(mk(7'h60, 13'd4, 11'd1, 3'd0,
          16'h0400, 8'(8'h40 + i), 3'd0, 32'h20000060,
          0, 8'h0F));
      drive(1, 0, 16'h0060, 11'd1, 16'h0400,
            8'(8'h40 + i), 0, 7'h60);
    end
    repeat (2) @(negedge clk);
    chk("ovf_pulses", 256'(ovf_seen), 256'd2);
    chk("ovf_count", 256'(ovf_count), 256'd2);
    @(posedge clk);
    #1;
    bus.s_axis_cc_tready = 1'b1;
    wait_idle();
    chk("ovf_beats", 256'(hs), 256'(h0 + 5));
    chk("sb_drained", 256'(sb.size()), 0);

    // Reset in SEND with two queued entries
    bus.s_axis_cc_tready = 1'b0;
    for (int i = 0; i < 3; i++)
      drive(1, 0, 16'h0010, 11'd1, 16'h0500,
            8'(8'h70 + i), 0, 7'h10);
    wait_tvalid();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_send_tvalid", 256'(bus.s_axis_cc_tvalid), 0);
    chk("rst_send_busy", 256'(busy), 0);
    chk("rst_send_ovf_cnt", 256'(ovf_count), 0);
    h0 = hs;
    @(posedge clk);
    #1;
    bus.s_axis_cc_tready = 1'b1;
    repeat (30) @(negedge clk);
    chk("rst_no_beats", 256'(hs), 256'(h0));
    chk("rst_idle_busy", 256'(busy), 0);
    chk("sb_final", 256'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end
endmodule

// File: doc/cc_read_completer.md
Name: cc_read_completer

Overview:
Sits directly downstream of the CQ descriptor parser and upstream of the PCIe core's CC (completer completion) AXI-Stream interface. Queues BAR memory-read descriptors, fetches 64-bit register data through a fixed-latency register-read port, and emits one single-beat CC completion per read. Memory writes are ignored here; the register file consumes them directly.

Parameters:
DATA_WIDTH, 256, CC AXI-Stream data width; only 256 is supported.
BAR0_SIZE, 16, register byte-address width.
FIFO_DEPTH, 4, read-request queue depth; must be a power of 2 and at least 2.
BAR_ID, 0, BAR number served; reads to any other BAR are dropped.

Ports:
clk  in  1  clock; single clock domain.
rst_n  in  1  synchronous reset, active-low.
cq_valid  in  1  descriptor valid this cycle.
cq_is_read  in  1  descriptor is a memory read.
cq_bar_id  in  3  target BAR.
cq_reg_addr  in  BAR0_SIZE  DW-aligned byte address.
cq_dword_count  in  11  requested DW count.
cq_requester_id  in  16  requester ID.
cq_tag  in  8  request tag.
cq_tc  in  3  traffic class.
cq_lower_addr  in  7  lower address for the completion.
reg_rd_en  out  1  register read strobe, 1 cycle.
reg_rd_addr  out  BAR0_SIZE  QW-aligned read address (bits [2:0] = 0).
reg_rd_data  in  64  read data, valid exactly 1 cycle after reg_rd_en.
s_axis_cc_tdata  out  DATA_WIDTH  completion beat.
s_axis_cc_tkeep  out  DATA_WIDTH/32  DW enables.
s_axis_cc_tlast  out  1  always equal to tvalid.
s_axis_cc_tuser  out  33  constant 0.
s_axis_cc_tvalid  out  1  beat valid.
s_axis_cc_tready  in  1  core ready.
ovf_pulse  out  1  1-cycle pulse when a read is dropped because the queue is full.
ovf_count  out  16  saturating count of dropped reads.
busy  out  1  high when the queue is non-empty or the FSM is not in IDLE.

Behaviour:
- Push: when cq_valid & cq_is_read & (cq_bar_id == BAR_ID) & ~full, store {addr, dword_count, req_id, tag, tc, lower_addr}. Write descriptors and other BARs are never queued.
- Full: a push while full is dropped. ovf_pulse is asserted the next cycle and ovf_count increments, saturating at 16'hFFFF. A push and a pop in the same cycle while full are both accepted.
- FSM states IDLE, RD, WAIT, SEND, with registered outputs:
  - IDLE: if the queue is non-empty, pop the head into a working register and go to RD.
  - RD: reg_rd_en = 1; reg_rd_addr = {addr[BAR0_SIZE-1:3], 3'b000}; go to WAIT.
  - WAIT: capture reg_rd_data; go to SEND.
  - SEND: s_axis_cc_tvalid = 1. tdata, tkeep and tlast stay stable until tready. On tvalid & tready, go to IDLE.
- Latency: cq_valid sampled in cycle 0 gives reg_rd_en in cycle 2 and tvalid in cycle 4. Maximum throughput is one completion per 4 cycles.
- Descriptor fields (tdata bit positions):
  - [6:0] lower_addr; [9:8] = 0; [28:16] byte_count; [29] = 0.
  - [42:32] dword_count_out; [45:43] status; [46] = 0; [63:48] requester_id.
  - [71:64] tag; [87:72] = 0; [88] = 0; [91:89] tc; [95:92] = 0.
- Supported read, dword_count 1:
  - status 3'b000; byte_count 4; dword_count_out 1.
  - [127:96] = addr[2] ? reg_data[63:32] : reg_data[31:0].
  - tkeep 8'h0F.
- Supported read, dword_count 2 with addr[2] = 0:
  - byte_count 8; dword_count_out 2.
  - [127:96] = reg_data[31:0]; [159:128] = reg_data[63:32].
  - tkeep 8'h1F.
- Unsupported read (dword_count 0, >2, or 2 with addr[2] = 1):
  - status 3'b001 (UR); byte_count 0; dword_count_out 0; tkeep 8'h07; no payload.
  - The register read is still issued and its data is discarded.
- All unused tdata bits are 0.
- Reset: the FSM goes to IDLE and the queue empties. reg_rd_en, tvalid, tlast, ovf_pulse, busy, ovf_count, tdata and tkeep are all 0 on the first clk edge with rst_n low. A completion in flight during reset is abandoned, not resent.
- Pointer arithmetic wraps modulo FIFO_DEPTH. Full and empty are distinguished by an extra pointer bit.

Test Plan:
- Single 1-DW read, addr 16'h0014, tag 8'h2A, req_id 16'h0100, reg_rd_data 64'hDEADBEEF_CAFEF00D, tready = 1 -> reg_rd_addr 16'h0010 in cycle 2; beat in cycle 4 with [127:96] = 32'hDEADBEEF, byte_count 4, tkeep 8'h0F, tag 8'h2A.
- 2-DW read at addr 16'h0020 -> [127:96] = low word, [159:128] = high word, dword_count_out 2, byte_count 8, tkeep 8'h1F.
- tready held low 10 cycles during SEND -> tvalid stays high and tdata/tkeep are unchanged; exactly one handshake on release.
- 6 back-to-back reads with tready = 0 (FIFO_DEPTH = 4) -> 4 accepted, 2 ovf_pulse events, ovf_count = 2; after release, 4 completions in order with tags matching the accepted requests.
- dword_count 3 and a write to BAR 0 -> read returns status UR, tkeep 8'h07; write produces no completion and busy stays low.
- rst_n low for 1 cycle while in SEND with 2 entries queued -> tvalid is 0 the next cycle, busy is 0, and no completions are emitted afterward.
